irq_controller: RTL and testbench

- Memory-mapped interrupt controller between the peripheral interrupt sources (Timer, future UART/keys) and the pipelined CPU's `interrupt` input.
- Latches source rising edges into pending bits and applies an enable mask.
- Selects one source by fixed priority.
- Sequences the request / in-service / end-of-interrupt handshake with the core's kernel-mode flag (PC[31]).
- Register reads are muxed into the MEM-stage Read_data path alongside DataMemory and SysClk.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/irq_prio_enc.sv | 22 ++
 rtl/irq_controller.sv | 137 +++++++++++++
 tb/tb_irq_controller.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU's memory-mapped interrupt controller:
// register offsets, default base address and FSM state encoding.
package cpu_pkg;

    localparam logic [31:0] IRQ_BASE_ADDR = 32'h40000020;

    localparam logic [3:0] IRQ_ENABLE  = 4'd0;
    localparam logic [3:0] IRQ_PENDING = 4'd4;
    localparam logic [3:0] IRQ_CAUSE   = 4'd8;
    localparam logic [3:0] IRQ_EOI     = 4'd12;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational fixed-priority encoder: returns the lowest set index of
// i_req and whether any bit was set.
module irq_prio_enc #(
    parameter int N_SRC = 4
) (
    input  logic [N_SRC-1:0] i_req,
    output logic [2:0]       o_idx,
    output logic             o_valid
);

    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (i_req[i] && !o_valid) begin
                o_idx   = 3'(i);
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: edge-latched pending bits, enable
// mask, fixed-priority selection and request/service/EOI handshake.
module irq_controller
    import cpu_pkg::*;
#(
    parameter int          N_SRC     = 4,
    parameter logic [31:0] BASE_ADDR = IRQ_BASE_ADDR
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      Address,
    input  logic [31:0]      Write_data,
    input  logic             MemWrite,
    input  logic             MemRead,
    output logic [31:0]      Read_data,
    output logic             hit,
    input  logic             in_kernel,
    input  logic [N_SRC-1:0] irq_src,
    output logic             irq,
    output logic [2:0]       cause
);

    irq_state_t       r_state, w_state_nxt;
    logic [2:0]       r_cause, w_cause_nxt;
    logic [N_SRC-1:0] r_enable, r_pending, r_src_q;
    logic             r_in_kernel_q;
    logic             r_armed;

    logic [31:0]      w_off;
    logic             w_in_range;
    logic [3:0]       w_reg;
    logic             w_wr, w_wr_en, w_wr_pend, w_wr_eoi;
    logic [N_SRC-1:0] w_rise, w_w1c, w_cause_mask, w_acc_clr;
    logic [N_SRC-1:0] w_pend_nxt, w_en_nxt, w_masked;
    logic [2:0]       w_sel;
    logic             w_cand, w_accept, w_withdraw, w_active;
    logic [31:0]      w_rd;
    logic             w_unused;

    assign w_off      = {Address[31:2], 2'b00} - BASE_ADDR;
    assign w_in_range = (w_off[31:4] == '0);
    assign w_reg      = w_off[3:0];

    assign w_wr      = MemWrite & w_in_range;
    assign w_wr_en   = w_wr && (w_reg == IRQ_ENABLE);
    assign w_wr_pend = w_wr && (w_reg == IRQ_PENDING);
    assign w_wr_eoi  = w_wr && (w_reg == IRQ_EOI);

    // Edges are suppressed on the first cycle after reset so a source held
    // high through reset is not mistaken for a new rising edge.
    assign w_rise = irq_src & ~r_src_q & {N_SRC{r_armed}};
    assign w_w1c  = w_wr_pend ? Write_data[N_SRC-1:0] : '0;

    assign w_cause_mask = N_SRC'(1) << r_cause;
    assign w_accept     = (r_state == REQ) && in_kernel && !r_in_kernel_q;
    assign w_acc_clr    = w_accept ? w_cause_mask : '0;

    assign w_pend_nxt = (r_pending & ~(w_w1c | w_acc_clr)) | w_rise;
    assign w_en_nxt   = w_wr_en ? Write_data[N_SRC-1:0] : r_enable;

    // Withdrawal looks at next-cycle values so a same-cycle new edge keeps the request.
    assign w_withdraw = ~|(w_pend_nxt & w_cause_mask) | ~|(w_en_nxt & w_cause_mask);

    assign w_masked = r_pending & r_enable;

    irq_prio_enc #(
        .N_SRC (N_SRC)
    ) u_prio_enc (
        .i_req   (w_masked),
        .o_idx   (w_sel),
        .o_valid (w_cand)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cause_nxt = r_cause;
        case (r_state)
            IDLE: begin
                if (w_cand) begin
                    w_state_nxt = REQ;
                    w_cause_nxt = w_sel;
                end
            end
            REQ: begin
                if (w_accept)
                    w_state_nxt = SERVICE;
                else if (w_withdraw)
                    w_state_nxt = IDLE;
            end
            SERVICE: begin
                if (w_wr_eoi)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_cause       <= '0;
            r_enable      <= '0;
            r_pending     <= '0;
            r_src_q       <= '0;
            r_in_kernel_q <= 1'b0;
            r_armed       <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cause       <= w_cause_nxt;
            r_enable      <= w_en_nxt;
            r_pending     <= w_pend_nxt;
            r_src_q       <= irq_src;
            r_in_kernel_q <= in_kernel;
            r_armed       <= 1'b1;
        end
    end

    assign w_active = (r_state == SERVICE);
    assign irq      = (r_state == REQ);
    assign cause    = r_cause;

    always_comb begin
        w_rd = '0;
        case (w_reg)
            IRQ_ENABLE:  w_rd[N_SRC-1:0] = r_enable;
            IRQ_PENDING: w_rd[N_SRC-1:0] = r_pending;
            IRQ_CAUSE:   w_rd[3:0]       = {w_active, r_cause};
            default:     w_rd            = '0;
        endcase
    end

    assign hit       = w_in_range & MemRead;
    assign Read_data = hit ? w_rd : '0;

    assign w_unused = ^{Address[1:0], Write_data[31:N_SRC]};

endmodule

// File: tb/tb_irq_controller.sv
// Scenario bench for irq_controller: expectations are queued when stimulus
// is driven and popped when the corresponding output is sampled.
module tb_irq_controller;
    import cpu_pkg::*;

    localparam int          N    = 4;
    localparam logic [31:0] BASE = 32'h40000020;

    logic          clk;
    logic          reset;
    logic [31:0]   Address;
    logic [31:0]   Write_data;
    logic          MemWrite;
    logic          MemRead;
    logic [31:0]   Read_data;
    logic          hit;
    logic          in_kernel;
    logic [N-1:0]  irq_src;
    logic          irq;
    logic [2:0]    cause;

    logic [31:0] exp_q[$];
    int          vectors;
    int          miscompares;

    irq_controller #(
        .N_SRC     (N),
        .BASE_ADDR (BASE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .Address    (Address),
        .Write_data (Write_data),
        .MemWrite   (MemWrite),
        .MemRead    (MemRead),
        .Read_data  (Read_data),
        .hit        (hit),
        .in_kernel  (in_kernel),
        .irq_src    (irq_src),
        .irq        (irq),
        .cause      (cause)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] off, input logic [31:0] d);
        Address    = BASE + off;
        Write_data = d;
        MemWrite   = 1'b1;
        tick();
        MemWrite   = 1'b0;
        Address    = '0;
        Write_data = '0;
    endtask

    task automatic bus_read(input logic [31:0] off, output logic [31:0] d, output logic h);
        Address = BASE + off;
        MemRead = 1'b1;
        #1;
        d       = Read_data;
        h       = hit;
        MemRead = 1'b0;
        Address = '0;
    endtask

    function automatic logic [31:0] irq_obs();
        return {28'b0, cause, irq};
    endfunction

    task automatic test_reset();
        logic [31:0] rd, ex;
        logic        h;
        #1;
        exp_q.push_back(32'h0);
        ex = exp_q.pop_front(); vectors++;
        if (irq_obs() !== ex) begin miscompares++; $display("FAIL rst_irq_cause: got %h want %h", irq_obs(), ex); end
        exp_q.push_back(32'h0);
        ex = exp_q.pop_front(); vectors++;
        if ({31'b0, hit} !== ex || Read_data !== 32'h0) begin miscompares++; $display("FAIL rst_hit: got hit=%b rd=%h want 0", hit, Read_data); end
        exp_q.push_back(32'h0);
        bus_read(32'(IRQ_ENABLE), rd, h);
        ex = exp_q.pop_front(); vectors++;
        if (rd !== ex) begin miscompares++; $display("FAIL rst_enable: got %h want %h", rd, ex); end
        repeat (2) tick();
        reset = 1'b0;
        tick();
        exp_q.push_back(32'h0);
        bus_read(32'(IRQ_PENDING), rd, h);
        ex = exp_q.pop_front(); vectors++;
        if (rd !== ex) begin miscompares++; $display("FAIL rst_pending: got %h want %h", rd, ex); end
    endtask

    task automatic test_single();
        logic [31:0] rd, ex;
        logic        h;
        bus_write(32'(IRQ_ENABLE), 32'h1);
        irq_src = 4'b0001;
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h0);
        tick();
        bus_read(32'(IRQ_PENDING), rd, h);
        ex = exp_q.pop_front(); vectors++;
        if (rd !== ex) begin miscompares++; $display("FAIL single_pending: got %h want %h", rd, ex); end
        ex = exp_q.pop_front(); vectors++;
        if (irq_obs() !== ex) begin miscompares++; $display("FAIL single_no_irq_yet: got %h want %h", irq_obs(), ex); end
        irq_src = '0;
        exp_q.push_back(32'h1);
        tick();
        ex = exp_q.pop_front(); vectors++;
        if (irq_obs() !== ex) begin miscompares++; $display("FAIL single_req: got %h want %h", irq_obs(), ex); end
        exp_q.push_back(32'h1);
        repeat (2) tick();
        ex = exp_q.pop_front(); vectors++;
        if (irq_obs() !== ex) begin miscompares++; $display("FAIL single_req_hold: got %h want %h", irq_obs(), ex); end
        in_kernel = 1'b1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h8);
        exp_q.push_back(32'h0);
        tick();
        ex = exp_q.pop_front(); vectors++;
        if (irq_obs() !== ex) begin miscompares++; $display("FAIL single_accept: got %h want %h", irq_obs(), ex); end
        bus_read(32'(IRQ_CAUSE), rd, h);
        ex = exp_q.pop_front(); vectors++;
        if (rd !== ex) begin miscompares++; $display("FAIL single_cause_reg: got %h want %h", rd, ex); end
        bus_read(32'(IRQ_PENDING), rd, h);
        ex = exp_q.pop_front(); vectors++;
        if (rd !== ex) begin miscompares++; $display("FAIL single_pend_cleared: got %h want %h", rd, ex); end
        exp_q.push_back(32'h0);
        bus_write(32'(IRQ_EOI), 32'h0);
        bus_read(32'(IRQ_CAUSE), rd, h);
        ex = exp_q.pop_front(); vectors++;
        if (rd !== ex) begin miscompares++; $display("FAIL single_eoi_cause: got %h want %h", rd, ex); end
        in_kernel = 1'b0;
        tick();
    endtask

    task automatic test_priority();
        logic [31:0] rd, ex;
        logic        h;
        bus_write(32'(IRQ_ENABLE), 32'hF);
        irq_src = 4'b1010;
        tick();
        irq_src = '0;
        exp_q.push_back({28'b0, 3'd1, 1'b1});
        tick();
        ex = exp_q.pop_front(); vectors++;
        if (irq_obs() !== ex) begin miscompares++; $display("FAIL prio_sel1: got %h want %h", irq_obs(), ex); end
        in_kernel = 1'b1;
        tick();
        exp_q.push_back(32'h8);
        bus_read(32'(IRQ_PENDING), rd, h);
        ex = exp_q.pop_front(); vectors++;
        if (rd !== ex) begin miscompares++; $display("FAIL prio_pend_left: got %h want %h", rd, ex); end
        // in_kernel stays high through EOI so the next REQ starts with it already set
        exp_q.push_back({28'b0, 3'd1, 1'b0});
        exp_q.push_back({28'b0, 3'd3, 1'b1});
        exp_q.push_back({28'b0, 3'd3, 1'b1});
        exp_q.push_back({28'b0, 3'd3, 1'b0});
        exp_q.push_back(32'hB);
        bus_write(32'(IRQ_EOI), 32'h0);
        ex = exp_q.pop_front(); vectors++;
        if (irq_obs() !== ex) begin miscompares++; $display("FAIL prio_eoi_idle: got %h want %h", irq_obs(), ex); end
        tick();
        ex = exp_q.pop_front(); vectors++;
        if (irq_obs() !== ex) begin miscompares++; $display("FAIL prio_sel3: got %h want %h", irq_obs(), ex); end
        repeat (2) tick();
        in_kernel = 1'b0;
        tick();
        ex = exp_q.pop_front(); vectors++;
        if (irq_obs() !== ex) begin miscompares++; $display("FAIL prio_kernel_held: got %h want %h", irq_obs(), ex); end
        in_kernel = 1'b1;
        tick();
        ex = exp_q.pop_front(); vectors++;
        if (irq_obs() !== ex) begin miscompares++; $display("FAIL prio_accept3: got %h want %h", irq_obs(), ex); end
        bus_read(32'(IRQ_CAUSE), rd, h);
        ex = exp_q.pop_front(); vectors++;
        if (rd !== ex) begin miscompares++; $display("FAIL prio_cause_reg: got %h want %h", rd, ex); end
        bus_write(32'(IRQ_EOI), 32'h0);
        in_kernel = 1'b0;
        tick();
    endtask

    task automatic test_mask();
        logic [31:0] rd, ex;
        logic        h;
        bus_write(32'(IRQ_ENABLE), 32'h0);
        irq_src = 4'b0100;
        tick();
        irq_src = '0;
        tick();
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h0);
        bus_read(32'(IRQ_PENDING), rd, h);
        ex = exp_q.pop_front(); vectors++;
        if (rd !== ex) begin miscompares++; $display("FAIL mask_pending: got %h want %h", rd, ex); end
        ex = exp_q.pop_front(); vectors++;
        if ({31'b0, irq} !== ex) begin miscompares++; $display("FAIL mask_no_irq: got %b want %h", irq, ex); end
        exp_q.push_back(32'h0);
        exp_q.push_back({28'b0, 3'd2, 1'b1});
        bus_write(32'(IRQ_ENABLE), 32'h4);
        ex = exp_q.pop_front(); vectors++;
        if ({31'b0, irq} !== ex) begin miscompares++; $display("FAIL mask_unmask_idle: got %b want %h", irq, ex); end
        tick();
        ex = exp_q.pop_front(); vectors++;
        if (irq_obs() !== ex) begin miscompares++; $display("FAIL mask_unmask_req: got %h want %h", irq_obs(), ex); end
    endtask

    task automatic test_withdraw();
        logic [31:0] rd, ex;
        logic        h;
        exp_q.push_back({28'b0, 3'd2, 1'b0});
        exp_q.push_back(32'h0);
        bus_write(32'(IRQ_PENDING), 32'h4);
        ex = exp_q.pop_front(); vectors++;
        if (irq_obs() !== ex) begin miscompares++; $display("FAIL wd_w1c_irq: got %h want %h", irq_obs(), ex); end
        bus_read(32'(IRQ_PENDING), rd, h);
        ex = exp_q.pop_front(); vectors++;
        if (rd !== ex) begin miscompares++; $display("FAIL wd_w1c_pend: got %h want %h", rd, ex); end
        irq_src = 4'b0100;
        tick();
        irq_src = '0;
        tick();
        // new edge and W1C on the same bit in one cycle
        irq_src = 4'b0100;
        exp_q.push_back(32'h4);
        exp_q.push_back({28'b0, 3'd2, 1'b1});
        bus_write(32'(IRQ_PENDING), 32'h4);
        bus_read(32'(IRQ_PENDING), rd, h);
        ex = exp_q.pop_front(); vectors++;
        if (rd !== ex) begin miscompares++; $display("FAIL wd_set_wins: got %h want %h", rd, ex); end
        ex = exp_q.pop_front(); vectors++;
        if (irq_obs() !== ex) begin miscompares++; $display("FAIL wd_set_wins_irq: got %h want %h", irq_obs(), ex); end
        irq_src = '0;
        exp_q.push_back({28'b0, 3'd2, 1'b0});
        exp_q.push_back(32'h4);
        bus_write(32'(IRQ_ENABLE), 32'h0);
        ex = exp_q.pop_front(); vectors++;
        if (irq_obs() !== ex) begin miscompares++; $display("FAIL wd_disable_irq: got %h want %h", irq_obs(), ex); end
        bus_read(32'(IRQ_PENDING), rd, h);
        ex = exp_q.pop_front(); vectors++;
        if (rd !== ex) begin miscompares++; $display("FAIL wd_disable_pend: got %h want %h", rd, ex); end
        bus_write(32'(IRQ_PENDING), 32'hF);
    endtask

    task automatic test_decode();
        logic [31:0] rd, ex;
        logic        h;
        Address    = BASE + 32'(IRQ_ENABLE);
        Write_data = 32'hF;
        MemWrite   = 1'b0;
        tick();
        bus_write(32'd16, 32'hF);
        bus_write(32'hFFFF_FFFC, 32'hF);
        exp_q.push_back(32'h0);
        bus_read(32'(IRQ_ENABLE), rd, h);
        ex = exp_q.pop_front(); vectors++;
        if (rd !== ex) begin miscompares++; $display("FAIL dec_no_write: got %h want %h", rd, ex); end
        exp_q.push_back(32'h0);
        bus_read(32'd16, rd, h);
        ex = exp_q.pop_front(); vectors++;
        if ({h, rd[30:0]} !== ex) begin miscompares++; $display("FAIL dec_out_range: got hit=%b rd=%h want 0", h, rd); end
        bus_write(32'(IRQ_ENABLE), 32'h5);
        exp_q.push_back(32'h5);
        bus_read(32'd2, rd, h);
        ex = exp_q.pop_front(); vectors++;
        if (rd !== ex || h !== 1'b1) begin miscompares++; $display("FAIL dec_low_bits: got hit=%b rd=%h want %h", h, rd, ex); end
        exp_q.push_back(32'h0);
        bus_read(32'(IRQ_EOI), rd, h);
        ex = exp_q.pop_front(); vectors++;
        if (rd !== ex || h !== 1'b1) begin miscompares++; $display("FAIL dec_eoi_read: got hit=%b rd=%h want %h", h, rd, ex); end
        bus_write(32'(IRQ_ENABLE), 32'h0);
    endtask

    task automatic test_reset_hold();
        logic [31:0] rd, ex;
        logic        h;
        irq_src = 4'b0001;
        reset   = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        repeat (2) tick();
        exp_q.push_back(32'h0);
        bus_read(32'(IRQ_PENDING), rd, h);
        ex = exp_q.pop_front(); vectors++;
        if (rd !== ex) begin miscompares++; $display("FAIL hold_no_edge: got %h want %h", rd, ex); end
        irq_src = '0;
        tick();
        irq_src = 4'b0001;
        tick();
        exp_q.push_back(32'h1);
        bus_read(32'(IRQ_PENDING), rd, h);
        ex = exp_q.pop_front(); vectors++;
        if (rd !== ex) begin miscompares++; $display("FAIL hold_reedge: got %h want %h", rd, ex); end
        irq_src = '0;
    endtask

    task automatic test_reset_service();
        logic [31:0] rd, ex;
        logic        h;
        bus_write(32'(IRQ_ENABLE), 32'h1);
        tick();
        in_kernel = 1'b1;
        tick();
        exp_q.push_back(32'h8);
        bus_read(32'(IRQ_CAUSE), rd, h);
        ex = exp_q.pop_front(); vectors++;
        if (rd !== ex) begin miscompares++; $display("FAIL rsvc_in_service: got %h want %h", rd, ex); end
        reset = 1'b1;
        #1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        ex = exp_q.pop_front(); vectors++;
        if (irq_obs() !== ex) begin miscompares++; $display("FAIL rsvc_irq: got %h want %h", irq_obs(), ex); end
        bus_read(32'(IRQ_CAUSE), rd, h);
        ex = exp_q.pop_front(); vectors++;
        if (rd !== ex) begin miscompares++; $display("FAIL rsvc_cause: got %h want %h", rd, ex); end
        bus_read(32'(IRQ_ENABLE), rd, h);
        ex = exp_q.pop_front(); vectors++;
        if (rd !== ex) begin miscompares++; $display("FAIL rsvc_enable: got %h want %h", rd, ex); end
        tick();
        reset     = 1'b0;
        in_kernel = 1'b0;
        tick();
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        bus_write(32'(IRQ_EOI), 32'h0);
        bus_read(32'(IRQ_CAUSE), rd, h);
        ex = exp_q.pop_front(); vectors++;
        if (rd !== ex) begin miscompares++; $display("FAIL idle_eoi_cause: got %h want %h", rd, ex); end
        tick();
        ex = exp_q.pop_front(); vectors++;
        if (irq_obs() !== ex) begin miscompares++; $display("FAIL idle_eoi_irq: got %h want %h", irq_obs(), ex); end
    endtask

    initial begin
        clk         = 1'b0;
        reset       = 1'b1;
        Address     = '0;
        Write_data  = '0;
        MemWrite    = 1'b0;
        MemRead     = 1'b0;
        in_kernel   = 1'b0;
        irq_src     = '0;
        vectors     = 0;
        miscompares = 0;

        test_reset();
        test_single();
        test_priority();
        test_mask();
        test_withdraw();
        test_decode();
        test_reset_hold();
        test_reset_service();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
